mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the fetch stage (imem) and the memory stage (dmem).

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (imem) and memory-stage (dmem) request ports onto one memory port.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_imem_grants,
  output logic [31:0] perf_dmem_grants,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state;
  logic          owner_dmem;
  logic [CW-1:0] starve_cnt;

  logic imem_pend;
  logic dmem_pend;
  logic grant_dmem;
  logic grant_imem;
  logic done;

  assign imem_pend  = |imem_rmask;
  assign dmem_pend  = |(dmem_rmask | dmem_wmask);
  // dmem wins unless it has already been granted STARVE_LIMIT times in a row over a waiting fetch
  assign grant_dmem = dmem_pend && ((starve_cnt < LIMIT) || !imem_pend);
  assign grant_imem = imem_pend && !grant_dmem;
  assign done       = (state != IDLE) && mem_resp;

  // The mem_* registers double as the latched transaction; masks live for the ISSUE cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_dmem <= 1'b0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_rmask  <= '0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dmem) begin
            owner_dmem <= 1'b1;
            mem_addr   <= dmem_addr;
            mem_rmask  <= dmem_rmask;
            mem_wmask  <= dmem_wmask;
            mem_wdata  <= dmem_wdata;
            state      <= ISSUE;
            if (!imem_pend)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_imem) begin
            owner_dmem <= 1'b0;
            mem_addr   <= imem_addr;
            mem_rmask  <= imem_rmask;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
            state      <= ISSUE;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          mem_rmask <= '0;
          mem_wmask <= '0;
          if (mem_resp) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_resp  = done && !owner_dmem;
  assign dmem_resp  = done && owner_dmem;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = dmem_resp ? mem_rdata : '0;

  // A simultaneous load and store from dmem is a pipeline bug; it is still issued as given
  a_dmem_rw_exclusive: assert property (
    @(posedge clk) disable iff (rst)
    (state == IDLE && grant_dmem) |-> !((|dmem_rmask) && (|dmem_wmask)));

`ifdef ARB_PERF_CNT_EN
  logic stall;
  assign stall = (imem_pend && !imem_resp) || (dmem_pend && !dmem_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_imem_grants  <= '0;
      perf_dmem_grants  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state == IDLE && grant_imem) perf_imem_grants <= perf_imem_grants + 32'd1;
      if (state == IDLE && grant_dmem) perf_dmem_grants <= perf_dmem_grants + 32'd1;
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_imem_grants;
  logic [31:0] perf_dmem_grants;
  logic [31:0] perf_stall_cycles;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef ARB_PERF_CNT_EN
    , .perf_imem_grants(perf_imem_grants), .perf_dmem_grants(perf_dmem_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dreq_t;

  // requester agents
  logic [31:0] imem_q[$];
  dreq_t       dmem_q[$];
  bit          imem_active, dmem_active, imem_done, dmem_done;
  logic [31:0] imem_cur;
  dreq_t       dmem_cur;
  bit          gaps;

  // memory model
  bit rand_wait, force_stray, mem_busy;
  int fixed_w, mem_rem;

  // reference model: one transaction in flight, counted in cycles since its grant
  bit          m_busy, m_owner_d;
  int          m_age, m_streak, m_done;
  int          m_igrants, m_dgrants, m_stalls;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rmask, m_wmask;
  string       glog;

  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  logic [3:0]  e_rmask, e_wmask;
  logic        e_iresp, e_dresp;

  int total, bad;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_age = 0; m_streak = 0; m_done = 0;
    m_igrants = 0; m_dgrants = 0; m_stalls = 0; glog = "";
  endtask

  // One clock cycle: drive requesters and memory at negedge, then settle and update the model
  task automatic tick();
    bit ip, dp;
    @(negedge clk);
    if (imem_done) imem_active = 0;
    if (dmem_done) dmem_active = 0;
    if (!imem_active && imem_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
      imem_cur = imem_q.pop_front(); imem_active = 1;
    end
    if (!dmem_active && dmem_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
      dmem_cur = dmem_q.pop_front(); dmem_active = 1;
    end
    imem_addr  = imem_active ? imem_cur : $urandom;
    imem_rmask = imem_active ? 4'hf : 4'h0;
    dmem_addr  = dmem_active ? dmem_cur.addr : $urandom;
    dmem_rmask = dmem_active ? dmem_cur.rmask : 4'h0;
    dmem_wmask = dmem_active ? dmem_cur.wmask : 4'h0;
    dmem_wdata = dmem_active ? dmem_cur.wdata : $urandom;

    mem_resp  = 0;
    mem_rdata = $urandom;
    if ((mem_rmask | mem_wmask) != 0) begin
      mem_busy = 1;
      mem_rem  = rand_wait ? $urandom_range(0, 3) : fixed_w;
    end else if (mem_busy) begin
      mem_rem--;
    end
    if (force_stray) begin
      mem_resp = 1; mem_rdata = 32'hbad0bad0;
    end else if (mem_busy && mem_rem == 0) begin
      mem_resp = 1; mem_rdata = memfn(mem_addr); mem_busy = 0;
    end
    #1;

    ip = (imem_rmask != 0);
    dp = ((dmem_rmask | dmem_wmask) != 0);
    e_addr = 0; e_wdata = 0; e_rmask = 0; e_wmask = 0;
    e_iresp = 0; e_dresp = 0; e_irdata = 0; e_drdata = 0;
    if (m_busy) begin
      m_age++;
      e_addr = m_addr; e_wdata = m_wdata;
      if (m_age == 1) begin e_rmask = m_rmask; e_wmask = m_wmask; end
      if (mem_resp) begin
        if (m_owner_d) begin e_dresp = 1; e_drdata = memfn(m_addr); end
        else begin e_iresp = 1; e_irdata = memfn(m_addr); end
        m_busy = 0; m_done++;
      end
    end else if (dp && (m_streak < SL || !ip)) begin
      m_busy = 1; m_age = 0; m_owner_d = 1; m_dgrants++; glog = {glog, "D"};
      m_addr = dmem_addr; m_rmask = dmem_rmask; m_wmask = dmem_wmask; m_wdata = dmem_wdata;
      m_streak = ip ? ((m_streak + 1 > SL) ? SL : m_streak + 1) : 0;
    end else if (ip) begin
      m_busy = 1; m_age = 0; m_owner_d = 0; m_igrants++; glog = {glog, "I"};
      m_addr = imem_addr; m_rmask = imem_rmask; m_wmask = 0; m_wdata = 0;
      m_streak = 0;
    end
    if ((ip && !e_iresp) || (dp && !e_dresp)) m_stalls++;
    imem_done = imem_resp;
    dmem_done = dmem_resp;
  endtask

  task automatic do_reset();
    rst = 1;
    imem_q.delete(); dmem_q.delete();
    imem_active = 0; dmem_active = 0; imem_done = 0; dmem_done = 0;
    imem_addr = 0; imem_rmask = 0; dmem_addr = 0; dmem_rmask = 0; dmem_wmask = 0; dmem_wdata = 0;
    mem_resp = 0; mem_rdata = 0; mem_busy = 0; mem_rem = 0; force_stray = 0;
    gaps = 0; rand_wait = 0; fixed_w = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    imem_rmask = 4'hf; imem_addr = 32'h1000;
    dmem_wmask = 4'h3; dmem_rmask = 0; dmem_addr = 32'h2000; dmem_wdata = 32'h1234;
    mem_resp = 1; mem_rdata = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1;
    total += 8;
    if (mem_addr !== 0)   begin bad++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    if (mem_rmask !== 0)  begin bad++; $display("[TB] FAIL reset_mem_rmask got=%h exp=0", mem_rmask); end
    if (mem_wmask !== 0)  begin bad++; $display("[TB] FAIL reset_mem_wmask got=%h exp=0", mem_wmask); end
    if (mem_wdata !== 0)  begin bad++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    if (imem_resp !== 0)  begin bad++; $display("[TB] FAIL reset_imem_resp got=%b exp=0", imem_resp); end
    if (dmem_resp !== 0)  begin bad++; $display("[TB] FAIL reset_dmem_resp got=%b exp=0", dmem_resp); end
    if (imem_rdata !== 0) begin bad++; $display("[TB] FAIL reset_imem_rdata got=%h exp=0", imem_rdata); end
    if (dmem_rdata !== 0) begin bad++; $display("[TB] FAIL reset_dmem_rdata got=%h exp=0", dmem_rdata); end
`ifdef ARB_PERF_CNT_EN
    total++;
    if ((perf_imem_grants | perf_dmem_grants | perf_stall_cycles) !== 0) begin
      bad++; $display("[TB] FAIL reset_perf got=%h/%h/%h exp=0", perf_imem_grants, perf_dmem_grants, perf_stall_cycles);
    end
`endif
    do_reset();
  endtask

  task automatic test_imem_only();
    do_reset();
    imem_q.push_back(32'h1eceb000);
    tick();
    tick();
    total += 6;
    if (mem_rmask !== 4'hf) begin bad++; $display("[TB] FAIL imem_only_rmask got=%h exp=f", mem_rmask); end
    if (mem_wmask !== 4'h0) begin bad++; $display("[TB] FAIL imem_only_wmask got=%h exp=0", mem_wmask); end
    if (mem_addr !== 32'h1eceb000) begin bad++; $display("[TB] FAIL imem_only_addr got=%h exp=1eceb000", mem_addr); end
    if (imem_resp !== 1'b1) begin bad++; $display("[TB] FAIL imem_only_resp got=%b exp=1", imem_resp); end
    if (imem_rdata !== memfn(32'h1eceb000)) begin
      bad++; $display("[TB] FAIL imem_only_rdata got=%h exp=%h", imem_rdata, memfn(32'h1eceb000));
    end
    if (dmem_resp !== 1'b0) begin bad++; $display("[TB] FAIL imem_only_dmem_resp got=%b exp=0", dmem_resp); end
    tick();
    total += 2;
    if (mem_rmask !== 4'h0) begin bad++; $display("[TB] FAIL imem_only_rmask_after got=%h exp=0", mem_rmask); end
    if (imem_resp !== 1'b0) begin bad++; $display("[TB] FAIL imem_only_resp_after got=%b exp=0", imem_resp); end
  endtask

  task automatic test_same_cycle();
    dreq_t d;
    do_reset();
    d.addr = 32'h1eceb010; d.rmask = 0; d.wmask = 4'h3; d.wdata = 32'h0000beef;
    dmem_q.push_back(d);
    imem_q.push_back(32'h1eceb000);
    tick();
    tick();
    total += 5;
    if (mem_wmask !== 4'h3) begin bad++; $display("[TB] FAIL same_cycle_wmask got=%h exp=3", mem_wmask); end
    if (mem_addr !== 32'h1eceb010) begin bad++; $display("[TB] FAIL same_cycle_addr got=%h exp=1eceb010", mem_addr); end
    if (mem_wdata !== 32'h0000beef) begin bad++; $display("[TB] FAIL same_cycle_wdata got=%h exp=0000beef", mem_wdata); end
    if (dmem_resp !== 1'b1) begin bad++; $display("[TB] FAIL same_cycle_dmem_resp got=%b exp=1", dmem_resp); end
    if (imem_resp !== 1'b0) begin bad++; $display("[TB] FAIL same_cycle_imem_early got=%b exp=0", imem_resp); end
    tick();
    total++;
    if ((mem_rmask | mem_wmask) !== 4'h0) begin bad++; $display("[TB] FAIL same_cycle_gap got=%h exp=0", mem_rmask | mem_wmask); end
    tick();
    total += 3;
    if (mem_rmask !== 4'hf) begin bad++; $display("[TB] FAIL same_cycle_imem_rmask got=%h exp=f", mem_rmask); end
    if (mem_addr !== 32'h1eceb000) begin bad++; $display("[TB] FAIL same_cycle_imem_addr got=%h exp=1eceb000", mem_addr); end
    if (imem_resp !== 1'b1) begin bad++; $display("[TB] FAIL same_cycle_imem_resp got=%b exp=1", imem_resp); end
  endtask

  task automatic test_starvation();
    dreq_t d;
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d.addr = 32'h2000 + 32'(i * 4); d.rmask = (i % 2 == 0) ? 4'hf : 4'h0;
      d.wmask = (i % 2 == 0) ? 4'h0 : 4'hc; d.wdata = 32'(i) * 32'h01010101;
      dmem_q.push_back(d);
    end
    imem_q.push_back(32'h3000);
    imem_q.push_back(32'h3004);
    cyc = 0;
    while ((glog.len() < 6 || m_busy) && cyc < 80) begin
      tick();
      cyc++;
    end
    total++;
    if (glog != "DDIDDI") begin bad++; $display("[TB] FAIL starve_sequence got=%s exp=DDIDDI", glog); end
    @(posedge clk);
    #1;
`ifdef ARB_PERF_CNT_EN
    total += 3;
    if (perf_dmem_grants !== 32'd4) begin bad++; $display("[TB] FAIL perf_dmem_grants got=%0d exp=4", perf_dmem_grants); end
    if (perf_imem_grants !== 32'd2) begin bad++; $display("[TB] FAIL perf_imem_grants got=%0d exp=2", perf_imem_grants); end
    if (perf_stall_cycles !== 32'(m_stalls)) begin
      bad++; $display("[TB] FAIL perf_stall_cycles got=%0d exp=%0d", perf_stall_cycles, m_stalls);
    end
`endif
  endtask

  task automatic test_wait_states();
    dreq_t d;
    do_reset();
    fixed_w = 3;
    d.addr = 32'h1eceb020; d.rmask = 4'hf; d.wmask = 0; d.wdata = 0;
    dmem_q.push_back(d);
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      total += 3;
      if (mem_rmask !== ((i == 1) ? 4'hf : 4'h0)) begin
        bad++; $display("[TB] FAIL wait_rmask cyc=%0d got=%h exp=%h", i, mem_rmask, (i == 1) ? 4'hf : 4'h0);
      end
      if (mem_addr !== 32'h1eceb020) begin bad++; $display("[TB] FAIL wait_addr cyc=%0d got=%h exp=1eceb020", i, mem_addr); end
      if (dmem_resp !== (i == 4)) begin bad++; $display("[TB] FAIL wait_resp cyc=%0d got=%b exp=%b", i, dmem_resp, i == 4); end
    end
    total++;
    if (dmem_rdata !== memfn(32'h1eceb020)) begin
      bad++; $display("[TB] FAIL wait_rdata got=%h exp=%h", dmem_rdata, memfn(32'h1eceb020));
    end
    tick();
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wait_addr_idle got=%h exp=0", mem_addr); end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    fixed_w = 5;
    imem_q.push_back(32'h1eceb040);
    repeat (3) tick();
    rst = 1;
    #1;
    total += 4;
    if (mem_addr !== 0)   begin bad++; $display("[TB] FAIL midrst_addr got=%h exp=0", mem_addr); end
    if ((mem_rmask | mem_wmask) !== 0) begin bad++; $display("[TB] FAIL midrst_masks got=%h exp=0", mem_rmask | mem_wmask); end
    if (imem_resp !== 0)  begin bad++; $display("[TB] FAIL midrst_imem_resp got=%b exp=0", imem_resp); end
    if (imem_rdata !== 0) begin bad++; $display("[TB] FAIL midrst_imem_rdata got=%h exp=0", imem_rdata); end
    imem_q.delete(); imem_active = 0; imem_done = 0; imem_rmask = 0;
    mem_busy = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    force_stray = 1;
    tick();
    force_stray = 0;
    total += 4;
    if (imem_resp !== 0)  begin bad++; $display("[TB] FAIL stray_imem_resp got=%b exp=0", imem_resp); end
    if (dmem_resp !== 0)  begin bad++; $display("[TB] FAIL stray_dmem_resp got=%b exp=0", dmem_resp); end
    if (imem_rdata !== 0) begin bad++; $display("[TB] FAIL stray_imem_rdata got=%h exp=0", imem_rdata); end
    if (mem_addr !== 0)   begin bad++; $display("[TB] FAIL stray_addr got=%h exp=0", mem_addr); end
    tick();
    total++;
    if ((mem_rmask | mem_wmask) !== 0) begin bad++; $display("[TB] FAIL stray_state got=%h exp=0", mem_rmask | mem_wmask); end
  endtask

  task automatic test_random_traffic();
    logic [3:0] mtab[7];
    dreq_t d;
    int cyc;
    mtab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf};
    do_reset();
    gaps = 1;
    rand_wait = 1;
    for (int i = 0; i < 40; i++) begin
      imem_q.push_back($urandom & 32'hfffffffc);
      d.addr  = $urandom & 32'hfffffffc;
      d.wdata = $urandom;
      if ($urandom_range(0, 1) == 1) begin d.rmask = 0; d.wmask = mtab[$urandom_range(0, 6)]; end
      else begin d.rmask = mtab[$urandom_range(0, 6)]; d.wmask = 0; end
      dmem_q.push_back(d);
    end
    cyc = 0;
    while ((imem_q.size() > 0 || dmem_q.size() > 0 || imem_active || dmem_active || m_busy) && cyc < 4000) begin
      tick();
      cyc++;
      total += 8;
      if (mem_rmask !== e_rmask)   begin bad++; $display("[TB] FAIL rnd_rmask t=%0t got=%h exp=%h", $time, mem_rmask, e_rmask); end
      if (mem_wmask !== e_wmask)   begin bad++; $display("[TB] FAIL rnd_wmask t=%0t got=%h exp=%h", $time, mem_wmask, e_wmask); end
      if (mem_addr !== e_addr)     begin bad++; $display("[TB] FAIL rnd_addr t=%0t got=%h exp=%h", $time, mem_addr, e_addr); end
      if (mem_wdata !== e_wdata)   begin bad++; $display("[TB] FAIL rnd_wdata t=%0t got=%h exp=%h", $time, mem_wdata, e_wdata); end
      if (imem_resp !== e_iresp)   begin bad++; $display("[TB] FAIL rnd_imem_resp t=%0t got=%b exp=%b", $time, imem_resp, e_iresp); end
      if (dmem_resp !== e_dresp)   begin bad++; $display("[TB] FAIL rnd_dmem_resp t=%0t got=%b exp=%b", $time, dmem_resp, e_dresp); end
      if (imem_rdata !== e_irdata) begin bad++; $display("[TB] FAIL rnd_imem_rdata t=%0t got=%h exp=%h", $time, imem_rdata, e_irdata); end
      if (dmem_rdata !== e_drdata) begin bad++; $display("[TB] FAIL rnd_dmem_rdata t=%0t got=%h exp=%h", $time, dmem_rdata, e_drdata); end
    end
    total++;
    if (m_done != 80) begin bad++; $display("[TB] FAIL rnd_completed got=%0d exp=80 cycles=%0d", m_done, cyc); end
    @(posedge clk);
    #1;
`ifdef ARB_PERF_CNT_EN
    total += 3;
    if (perf_imem_grants !== 32'(m_igrants)) begin bad++; $display("[TB] FAIL rnd_perf_igr got=%0d exp=%0d", perf_imem_grants, m_igrants); end
    if (perf_dmem_grants !== 32'(m_dgrants)) begin bad++; $display("[TB] FAIL rnd_perf_dgr got=%0d exp=%0d", perf_dmem_grants, m_dgrants); end
    if (perf_stall_cycles !== 32'(m_stalls)) begin bad++; $display("[TB] FAIL rnd_perf_stall got=%0d exp=%0d", perf_stall_cycles, m_stalls); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    imem_done = 0; dmem_done = 0; imem_active = 0; dmem_active = 0;
    gaps = 0; rand_wait = 0; force_stray = 0; fixed_w = 0; mem_busy = 0; mem_rem = 0;
    model_reset();
    test_reset();
    test_imem_only();
    test_same_cycle();
    test_starvation();
    test_wait_states();
    test_reset_mid_txn();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
